// File: rtl/core_readout_arbiter_if.sv
// Region-side and column-bus signal bundle for one core of the readout column.
interface core_readout_arbiter_if #(
  parameter int unsigned REGIONS    = 16,
  parameter int unsigned REG_PIXELS = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ROW_ADDR_W = 6,
  parameter int unsigned CNT_W      = 8
);
  localparam int unsigned RW    = $clog2(REGIONS);
  localparam int unsigned ROW_W = ROW_ADDR_W + RW;

  logic [REGIONS-1:0]            TokenPos;
  logic [REGIONS*DATA_W-1:0]     RegionData;
  logic [REGIONS-1:0]            RegionRead;
  logic                          TokIn;
  logic                          TokOut;
  logic                          Read;
  logic                          ValidIn;
  logic [DATA_W-1:0]             DataIn;
  logic [ROW_W-1:0]              RowIn;
  logic                          ValidOut;
  logic [DATA_W-1:0]             DataOut;
  logic [ROW_W-1:0]              RowOut;
  logic [ROW_ADDR_W-1:0]         AddressIn;
  logic [ROW_ADDR_W-1:0]         AddressOut;
  logic [REG_PIXELS*REGIONS-1:0] HitOr;
  logic [REG_PIXELS-1:0]         HitOrIn;
  logic [REG_PIXELS-1:0]         HitOrOut;
  logic                          CntClr;
  logic [CNT_W-1:0]              HitCnt;

  // Environment side: drives regions, upstream bus and control.
  modport master (
    output TokenPos, RegionData, TokIn, Read, ValidIn, DataIn, RowIn,
           AddressIn, HitOr, HitOrIn, CntClr,
    input  RegionRead, TokOut, ValidOut, DataOut, RowOut, AddressOut,
           HitOrOut, HitCnt
  );

  // Arbiter side.
  modport slave (
    input  TokenPos, RegionData, TokIn, Read, ValidIn, DataIn, RowIn,
           AddressIn, HitOr, HitOrIn, CntClr,
    output RegionRead, TokOut, ValidOut, DataOut, RowOut, AddressOut,
           HitOrOut, HitCnt
  );
endinterface

// File: rtl/core_readout_arbiter.sv
// Per-core readout arbiter: picks one pending region per Read cycle, merges it
// into a registered column-bus stage, and counts local HitOr activity.
module core_readout_arbiter #(
  parameter int unsigned REGIONS    = 16,
  parameter int unsigned REG_PIXELS = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ROW_ADDR_W = 6,
  parameter int unsigned ROWS       = 48,
  parameter int unsigned RR_MODE    = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  core_readout_arbiter_if.slave bus
);
  localparam int unsigned RW    = $clog2(REGIONS);
  localparam int unsigned ROW_W = ROW_ADDR_W + RW;

  logic [ROW_W-1:0]      r_row;
  logic [DATA_W-1:0]     r_data;
  logic                  r_valid;
  logic [REGIONS-1:0]    r_served;
  logic [RW-1:0]         r_rr_ptr;
  logic                  r_h_q;
  logic [CNT_W-1:0]      r_hit_cnt;

  logic [REGIONS-1:0]    w_elig;
  logic [RW-1:0]         w_sel;
  logic [RW-1:0]         w_idx;
  logic                  w_found;
  logic                  w_grant;
  logic [REGIONS-1:0]    w_onehot;
  logic [ROW_ADDR_W-1:0] w_core_row;
  logic [DATA_W-1:0]     w_sel_data;
  logic [REG_PIXELS-1:0] w_local_or;
  logic                  w_h;

  // Address chain and row offset of this core within the column.
  assign bus.AddressOut = bus.AddressIn - ROW_ADDR_W'(1);
  assign w_core_row     = bus.AddressIn - ROW_ADDR_W'(48 - int'(ROWS));

  // A region popped last cycle is masked so it cannot be popped back-to-back.
  assign w_elig     = bus.TokenPos & ~r_served;
  assign bus.TokOut = bus.TokIn | (|bus.TokenPos);

  // Region select: lowest index, or first index at/after rr_ptr with wrap.
  always_comb begin
    w_sel   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < int'(REGIONS); i++) begin
      if (RR_MODE != 0) w_idx = r_rr_ptr + RW'(i);
      else              w_idx = RW'(i);
      if (!w_found && w_elig[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_grant        = bus.Read & ~bus.TokIn & ~Reset & (|w_elig);
  assign w_onehot       = REGIONS'(1) << w_sel;
  assign bus.RegionRead = w_grant ? w_onehot : '0;
  assign w_sel_data     = bus.RegionData[int'(w_sel)*int'(DATA_W) +: DATA_W];

  // Column-bus stage: hold on stall, local word on grant, else forward upstream.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_row   <= '0;
    end else if (bus.Read) begin
      if (w_grant) begin
        r_valid <= 1'b1;
        r_data  <= w_sel_data;
        r_row   <= {w_core_row, w_sel};
      end else begin
        r_valid <= bus.ValidIn;
        r_data  <= bus.DataIn;
        r_row   <= bus.RowIn;
      end
    end
  end

  // Served mask and round-robin pointer bookkeeping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_served <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_served <= w_grant ? w_onehot : '0;
      if (w_grant && (RR_MODE != 0)) r_rr_ptr <= w_sel + RW'(1);
    end
  end

  assign bus.ValidOut = r_valid;
  assign bus.DataOut  = r_data;
  assign bus.RowOut   = r_row;

  // HitOr merge: per-lane OR across regions plus the upstream lane.
  always_comb begin
    w_local_or = '0;
    for (int p = 0; p < int'(REG_PIXELS); p++) begin
      w_local_or[p] = |bus.HitOr[p*int'(REGIONS) +: REGIONS];
    end
  end

  assign bus.HitOrOut = bus.HitOrIn | w_local_or;
  assign w_h          = |w_local_or;

  // Saturating rising-edge counter of local HitOr activity; clear wins.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_h_q     <= 1'b0;
      r_hit_cnt <= '0;
    end else begin
      r_h_q <= w_h;
      if (bus.CntClr) begin
        r_hit_cnt <= '0;
      end else if (w_h && !r_h_q && (r_hit_cnt != {CNT_W{1'b1}})) begin
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.HitCnt = r_hit_cnt;
endmodule

// File: tb/tb_core_readout_arbiter.sv
// Directed bench: fixed-priority core (dut0, ROWS=48) and round-robin core
// (dut1, ROWS=40) driven with the same stimulus.
module tb_core_readout_arbiter;
  logic         clk;
  logic         reset;
  logic [15:0]  tok_pos;
  logic [255:0] region_data;
  logic         tok_in;
  logic         read;
  logic         valid_in;
  logic [15:0]  data_in;
  logic [9:0]   row_in;
  logic [5:0]   address_in;
  logic [63:0]  hit_or;
  logic [3:0]   hit_or_in;
  logic         cnt_clr;

  int n_tests = 0;
  int n_fail  = 0;

  core_readout_arbiter_if if0 ();
  core_readout_arbiter_if if1 ();

  assign if0.TokenPos = tok_pos;     assign if1.TokenPos = tok_pos;
  assign if0.RegionData = region_data; assign if1.RegionData = region_data;
  assign if0.TokIn = tok_in;         assign if1.TokIn = tok_in;
  assign if0.Read = read;            assign if1.Read = read;
  assign if0.ValidIn = valid_in;     assign if1.ValidIn = valid_in;
  assign if0.DataIn = data_in;       assign if1.DataIn = data_in;
  assign if0.RowIn = row_in;         assign if1.RowIn = row_in;
  assign if0.AddressIn = address_in; assign if1.AddressIn = address_in;
  assign if0.HitOr = hit_or;         assign if1.HitOr = hit_or;
  assign if0.HitOrIn = hit_or_in;    assign if1.HitOrIn = hit_or_in;
  assign if0.CntClr = cnt_clr;       assign if1.CntClr = cnt_clr;

  core_readout_arbiter #(.ROWS(48), .RR_MODE(0)) dut0 (
    .Clk(clk), .Reset(reset), .bus(if0.slave)
  );
  core_readout_arbiter #(.ROWS(40), .RR_MODE(1)) dut1 (
    .Clk(clk), .Reset(reset), .bus(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [15:0] exp_rr0 [4];
  logic [15:0] exp_rr1 [4];
  logic [3:0]  exp_s;

  initial begin
    reset = 1'b1; tok_pos = 16'h0011; tok_in = 1'b0; read = 1'b1;
    valid_in = 1'b0; data_in = '0; row_in = '0; address_in = 6'd47;
    hit_or = '0; hit_or_in = '0; cnt_clr = 1'b0;
    for (int r = 0; r < 16; r++) region_data[r*16 +: 16] = 16'hA000 + 16'(r);

    // Reset with pending tokens and Read high.
    #1;
    check("rst_regionread", 32'(if0.RegionRead), 32'h0);
    tick();
    check("rst_valid", 32'(if0.ValidOut), 32'h0);
    check("rst_data", 32'(if0.DataOut), 32'h0);
    check("rst_row", 32'(if0.RowOut), 32'h0);
    check("rst_hitcnt", 32'(if0.HitCnt), 32'h0);
    check("addr_out", 32'(if0.AddressOut), 32'd46);
    reset = 1'b0;
    #1;
    check("post_rst_grant", 32'(if0.RegionRead), 32'h0001);
    tick();
    check("post_rst_data", 32'(if0.DataOut), 32'hA000);

    // Fixed priority, tokens drop one cycle after each pop.
    tok_pos = 16'h8005;
    do_reset();
    #1;
    check("fp_pop0", 32'(if0.RegionRead), 32'h0001);
    tick();
    check("fp_data0", 32'(if0.DataOut), 32'hA000);
    check("fp_row0", 32'(if0.RowOut), 32'({6'd47, 4'd0}));
    check("fp_valid0", 32'(if0.ValidOut), 32'h1);
    #1;
    check("fp_pop2", 32'(if0.RegionRead), 32'h0004);
    tick();
    check("fp_data2", 32'(if0.DataOut), 32'hA002);
    check("fp_row2", 32'(if0.RowOut), 32'({6'd47, 4'd2}));
    tok_pos = 16'h8004;
    #1;
    check("fp_pop15", 32'(if0.RegionRead), 32'h8000);
    tick();
    check("fp_data15", 32'(if0.DataOut), 32'hA00F);
    check("fp_row15", 32'(if0.RowOut), 32'({6'd47, 4'd15}));
    tok_pos = 16'h8000;
    #1;
    check("fp_served_mask", 32'(if0.RegionRead), 32'h0);
    tick();
    check("fp_drain_valid", 32'(if0.ValidOut), 32'h0);
    tok_pos = 16'h0000;
    #1;
    check("tokout_idle", 32'(if0.TokOut), 32'h0);

    // Upstream priority while TokIn is high.
    tok_pos = 16'h0002;
    do_reset();
    tok_in = 1'b1; valid_in = 1'b1; data_in = 16'hBEEF; row_in = 10'h155;
    #1;
    check("up_regionread", 32'(if0.RegionRead), 32'h0);
    check("up_tokout", 32'(if0.TokOut), 32'h1);
    tick();
    check("up_data", 32'(if0.DataOut), 32'hBEEF);
    check("up_row", 32'(if0.RowOut), 32'h155);
    check("up_valid", 32'(if0.ValidOut), 32'h1);
    tok_in = 1'b0; valid_in = 1'b0;
    #1;
    check("up_local_grant", 32'(if0.RegionRead), 32'h0002);
    check("local_tokout", 32'(if0.TokOut), 32'h1);
    tick();
    check("up_local_data", 32'(if0.DataOut), 32'hA001);
    check("up_local_row", 32'(if0.RowOut), 32'({6'd47, 4'd1}));

    // Stall: Read low holds the stage and blocks pops.
    read = 1'b0; valid_in = 1'b1; data_in = 16'h1234; row_in = 10'h3FF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_noread", 32'(if0.RegionRead), 32'h0);
      tick();
      check("stall_valid", 32'(if0.ValidOut), 32'h1);
      check("stall_data", 32'(if0.DataOut), 32'hA001);
      check("stall_row", 32'(if0.RowOut), 32'({6'd47, 4'd1}));
    end
    valid_in = 1'b0; read = 1'b1;

    // Round-robin vs fixed priority, two held tokens.
    exp_rr0 = '{16'h0001, 16'h0008, 16'h0001, 16'h0008};
    exp_rr1 = '{16'h0001, 16'h0008, 16'h0001, 16'h0008};
    tok_pos = 16'h0009;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_s = (exp_rr1[k] == 16'h0001) ? 4'd0 : 4'd3;
      #1;
      check("rr9_dut1", 32'(if1.RegionRead), 32'(exp_rr1[k]));
      check("rr9_dut0", 32'(if0.RegionRead), 32'(exp_rr0[k]));
      tick();
      check("rr9_data", 32'(if1.DataOut), 32'(16'hA000 + 16'(exp_s)));
      check("rr9_row", 32'(if1.RowOut), 32'({6'd39, exp_s}));
    end

    // Three held tokens separate the two arbitration modes.
    exp_rr0 = '{16'h0001, 16'h0002, 16'h0001, 16'h0002};
    exp_rr1 = '{16'h0001, 16'h0002, 16'h0004, 16'h0001};
    tok_pos = 16'h0007;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr7_dut1", 32'(if1.RegionRead), 32'(exp_rr1[k]));
      check("rr7_dut0", 32'(if0.RegionRead), 32'(exp_rr0[k]));
      tick();
    end
    tok_pos = 16'h0000;
    read = 1'b0;

    // HitOr activity counter: lane 2, region 5 is bit 37.
    do_reset();
    hit_or[37] = 1'b1;
    #1;
    check("hitor_out", 32'(if0.HitOrOut), 32'h4);
    tick();
    hit_or[37] = 1'b0;
    tick();
    check("hitcnt_1", 32'(if0.HitCnt), 32'd1);
    for (int k = 1; k < 10; k++) begin
      hit_or[37] = 1'b1; tick();
      hit_or[37] = 1'b0; tick();
    end
    check("hitcnt_10", 32'(if0.HitCnt), 32'd10);
    for (int k = 10; k < 300; k++) begin
      hit_or[37] = 1'b1; tick();
      hit_or[37] = 1'b0; tick();
    end
    check("hitcnt_sat", 32'(if0.HitCnt), 32'd255);
    check("hitcnt_sat_dut1", 32'(if1.HitCnt), 32'd255);
    hit_or[37] = 1'b1; cnt_clr = 1'b1;
    tick();
    check("hitcnt_clr", 32'(if0.HitCnt), 32'd0);
    cnt_clr = 1'b0;
    tick();
    check("hitcnt_no_edge", 32'(if0.HitCnt), 32'd0);
    hit_or[37] = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      hit_or_in = 4'b1001;
      #1;
      check("hitor_in_out", 32'(if0.HitOrOut), 32'h9);
      tick();
      hit_or_in = 4'b0000;
      #1;
      check("hitor_in_low", 32'(if0.HitOrOut), 32'h0);
      tick();
    end
    check("hitcnt_upstream_only", 32'(if0.HitCnt), 32'd0);
    hit_or[0] = 1'b1; tick();
    hit_or[0] = 1'b0; tick();
    check("hitcnt_after_clr", 32'(if0.HitCnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
